// File: rtl/change_monitor_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | change_monitor_if: sample/config/status bundle for change_monitor          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface change_monitor_if #(
    parameter int N_CH  = 4,
    parameter int DW    = 8,
    parameter int CNT_W = 8
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                 en;
    logic [2*N_CH-1:0]    mode;
    logic [N_CH*DW-1:0]   din;
    logic                 clr;
    logic [SEL_W-1:0]     cnt_sel;
    logic [N_CH-1:0]      chg;
    logic [N_CH-1:0]      viol;
    logic                 irq;
    logic [CNT_W-1:0]     cnt_out;

    modport master (
        output en, mode, din, clr, cnt_sel,
        input  chg, viol, irq, cnt_out
    );

    modport slave (
        input  en, mode, din, clr, cnt_sel,
        output chg, viol, irq, cnt_out
    );
endinterface
`default_nettype wire

// File: rtl/change_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | change_monitor: per-channel change detect, max-hold and min-stable checks  |
// | with saturating change counters, sticky violations and an interrupt.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module change_monitor #(
    parameter int N_CH       = 4,
    parameter int DW         = 8,
    parameter int CNT_W      = 8,
    parameter int HOLD_MAX   = 10,
    parameter int MIN_STABLE = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    change_monitor_if.slave  bus
);
    localparam logic [1:0]       C_MODE_OFF   = 2'b00;
    localparam logic [1:0]       C_MODE_HOLD  = 2'b10;
    localparam logic [1:0]       C_MODE_MIN   = 2'b11;
    localparam logic [CNT_W-1:0] C_CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_HOLD_LAST  = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] C_MIN_STABLE = CNT_W'(MIN_STABLE);

    logic [N_CH-1:0]  r_chg_vec;
    logic [N_CH-1:0]  r_viol_vec;
    logic [N_CH-1:0]  w_viol_nxt_vec;
    logic [CNT_W-1:0] w_cnt_arr [N_CH];
    logic             r_irq;
    logic [CNT_W-1:0] w_cnt_out;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [DW-1:0]    w_din;
        logic [1:0]       w_mode;
        logic [DW-1:0]    r_prev,  w_prev_nxt;
        logic             r_valid, w_valid_nxt;
        logic [1:0]       r_mode,  w_mode_nxt;
        logic [CNT_W-1:0] r_stab,  w_stab_nxt;
        logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
        logic             r_viol,  w_viol_nxt;
        logic             r_chg,   w_chg_nxt;
        logic             w_viol_evt;

        assign w_din  = bus.din[DW*gi +: DW];
        assign w_mode = bus.mode[2*gi +: 2];

        always_comb begin
            w_prev_nxt  = r_prev;
            w_valid_nxt = r_valid;
            w_mode_nxt  = r_mode;
            w_stab_nxt  = r_stab;
            w_cnt_nxt   = r_cnt;
            w_chg_nxt   = 1'b0;
            w_viol_evt  = 1'b0;

            if (bus.en) begin
                w_mode_nxt = w_mode;
                if (w_mode == C_MODE_OFF) begin
                    w_valid_nxt = 1'b0;
                    w_stab_nxt  = '0;
                end else if (!r_valid || (w_mode != r_mode)) begin
                    // First sample of a run only establishes the reference.
                    w_prev_nxt  = w_din;
                    w_valid_nxt = 1'b1;
                    w_stab_nxt  = '0;
                end else if (w_din != r_prev) begin
                    w_prev_nxt = w_din;
                    w_stab_nxt = '0;
                    w_chg_nxt  = 1'b1;
                    w_cnt_nxt  = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
                    w_viol_evt = (w_mode == C_MODE_MIN) && (r_stab < C_MIN_STABLE);
                end else begin
                    w_stab_nxt = (r_stab == C_CNT_MAX) ? r_stab : r_stab + 1'b1;
                    // Stab passes through HOLD_MAX-1 once per run, so this fires once.
                    w_viol_evt = (w_mode == C_MODE_HOLD) && (r_stab == C_HOLD_LAST);
                end
            end

            w_viol_nxt = r_viol | w_viol_evt;

            // An event coincident with clr survives the clear.
            if (bus.clr) begin
                w_cnt_nxt   = w_chg_nxt ? CNT_W'(1) : '0;
                w_viol_nxt  = w_viol_evt;
                w_valid_nxt = 1'b0;
                w_stab_nxt  = '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_prev  <= '0;
                r_valid <= 1'b0;
                r_mode  <= C_MODE_OFF;
                r_stab  <= '0;
                r_cnt   <= '0;
                r_viol  <= 1'b0;
                r_chg   <= 1'b0;
            end else begin
                r_prev  <= w_prev_nxt;
                r_valid <= w_valid_nxt;
                r_mode  <= w_mode_nxt;
                r_stab  <= w_stab_nxt;
                r_cnt   <= w_cnt_nxt;
                r_viol  <= w_viol_nxt;
                r_chg   <= w_chg_nxt;
            end
        end

        assign r_chg_vec[gi]      = r_chg;
        assign r_viol_vec[gi]     = r_viol;
        assign w_viol_nxt_vec[gi] = w_viol_nxt;
        assign w_cnt_arr[gi]      = r_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |w_viol_nxt_vec;
        end
    end

    always_comb begin
        w_cnt_out = '0;
        if (32'(bus.cnt_sel) < N_CH) begin
            w_cnt_out = w_cnt_arr[bus.cnt_sel];
        end
    end

    assign bus.chg     = r_chg_vec;
    assign bus.viol    = r_viol_vec;
    assign bus.irq     = r_irq;
    assign bus.cnt_out = w_cnt_out;

endmodule
`default_nettype wire

// File: tb/tb_change_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_change_monitor: directed vector table plus multi-cycle corner sequences |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_change_monitor;
    localparam int N_CH       = 4;
    localparam int DW         = 8;
    localparam int CNT_W      = 8;
    localparam int HOLD_MAX   = 10;
    localparam int MIN_STABLE = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    change_monitor_if #(.N_CH(N_CH), .DW(DW), .CNT_W(CNT_W)) bus ();

    change_monitor #(
        .N_CH(N_CH), .DW(DW), .CNT_W(CNT_W),
        .HOLD_MAX(HOLD_MAX), .MIN_STABLE(MIN_STABLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        en;
        logic [7:0]  mode;
        logic [31:0] din;
        logic        clr;
        logic [1:0]  sel;
        logic [3:0]  chg;
        logic [3:0]  viol;
        logic        irq;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] e_chg, input logic [3:0] e_viol,
                              input logic e_irq, input logic [7:0] e_cnt);
        check($sformatf("%s chg", tag),  32'(bus.chg),     32'(e_chg));
        check($sformatf("%s viol", tag), 32'(bus.viol),    32'(e_viol));
        check($sformatf("%s irq", tag),  32'(bus.irq),     32'(e_irq));
        check($sformatf("%s cnt", tag),  32'(bus.cnt_out), 32'(e_cnt));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    localparam logic [31:0] C_A = 32'h0011_0000;
    localparam logic [31:0] C_B = 32'h0022_0000;

    initial begin
        // en mode din clr sel | chg viol irq cnt
        vecs[0]  = '{1'b1, 8'h41, 32'h1000_0005, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 8'h41, 32'h1000_0005, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 8'h41, 32'h1000_0007, 1'b0, 2'd0, 4'h1, 4'h0, 1'b0, 8'd1};
        vecs[3]  = '{1'b1, 8'h41, 32'h1000_0007, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 8'd1};
        vecs[4]  = '{1'b1, 8'h41, 32'h1000_0002, 1'b0, 2'd0, 4'h1, 4'h0, 1'b0, 8'd2};
        vecs[5]  = '{1'b0, 8'h41, 32'h2000_0009, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 8'd2};
        vecs[6]  = '{1'b0, 8'h41, 32'h3000_0004, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 8'd2};
        vecs[7]  = '{1'b0, 8'h41, 32'h3100_0005, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 8'd2};
        vecs[8]  = '{1'b0, 8'h41, 32'h3200_0006, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 8'd2};
        vecs[9]  = '{1'b0, 8'h41, 32'h3300_0007, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 8'd2};
        vecs[10] = '{1'b1, 8'h41, 32'h1000_0009, 1'b0, 2'd0, 4'h1, 4'h0, 1'b0, 8'd3};
        vecs[11] = '{1'b1, 8'h41, 32'h1100_0009, 1'b0, 2'd3, 4'h8, 4'h0, 1'b0, 8'd1};
        vecs[12] = '{1'b1, 8'hC1, 32'h2200_0009, 1'b0, 2'd3, 4'h0, 4'h0, 1'b0, 8'd1};
        vecs[13] = '{1'b1, 8'hC1, 32'h2200_0009, 1'b0, 2'd3, 4'h0, 4'h0, 1'b0, 8'd1};
        vecs[14] = '{1'b1, 8'hC1, 32'h2300_0009, 1'b0, 2'd3, 4'h8, 4'h8, 1'b1, 8'd2};
        vecs[15] = '{1'b1, 8'hC1, 32'h2300_0009, 1'b1, 2'd0, 4'h0, 4'h0, 1'b0, 8'd0};
        vecs[16] = '{1'b1, 8'hC1, 32'h2300_0001, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 8'd0};
        vecs[17] = '{1'b1, 8'hC1, 32'h2300_0002, 1'b0, 2'd0, 4'h1, 4'h0, 1'b0, 8'd1};

        bus.en = 1'b0; bus.mode = '0; bus.din = '0; bus.clr = 1'b0; bus.cnt_sel = '0;

        #12;
        check_outs("reset", 4'h0, 4'h0, 1'b0, 8'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            bus.en      = vecs[i].en;
            bus.mode    = vecs[i].mode;
            bus.din     = vecs[i].din;
            bus.clr     = vecs[i].clr;
            bus.cnt_sel = vecs[i].sel;
            cyc();
            check_outs($sformatf("vec%0d", i), vecs[i].chg, vecs[i].viol, vecs[i].irq, vecs[i].cnt);
        end

        // Max-hold on ch1: 1 load + 10 stable samples trips the limit
        do_reset();
        bus.en = 1'b1; bus.mode = 8'h08; bus.din = 32'h0000_3300; bus.clr = 1'b0; bus.cnt_sel = 2'd1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check($sformatf("hold s%0d viol", k), 32'(bus.viol), (k >= 11) ? 32'h2 : 32'h0);
            check($sformatf("hold s%0d irq", k),  32'(bus.irq),  (k >= 11) ? 32'h1 : 32'h0);
        end
        bus.din = 32'h0000_3400;
        cyc();
        check_outs("hold change", 4'h2, 4'h2, 1'b1, 8'd1);
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
        check_outs("hold clr", 4'h0, 4'h0, 1'b0, 8'd0);

        // Min-stable on ch2: long run, change, 1 stable sample, change
        bus.mode = 8'h30; bus.cnt_sel = 2'd2;
        for (int k = 1; k <= 5; k++) begin
            bus.din = C_A;
            cyc();
            check($sformatf("mins run%0d chg", k), 32'(bus.chg), 32'h0);
        end
        bus.din = C_B; cyc();
        check_outs("mins chg1", 4'h4, 4'h0, 1'b0, 8'd1);
        bus.din = C_B; cyc();
        check_outs("mins hold", 4'h0, 4'h0, 1'b0, 8'd1);
        bus.din = C_A; cyc();
        check_outs("mins chg2", 4'h4, 4'h4, 1'b1, 8'd2);

        // Asynchronous reset mid-cycle with viol and cnt nonzero
        #3 rst_n = 1'b0;
        #1;
        check_outs("async rst", 4'h0, 4'h0, 1'b0, 8'd0);
        cyc();
        rst_n = 1'b1;
        bus.din = C_A; cyc();
        check_outs("post rst first", 4'h0, 4'h0, 1'b0, 8'd0);
        for (int k = 2; k <= 4; k++) begin
            bus.din = C_A; cyc();
        end
        bus.din = C_B; cyc();
        check_outs("mins ok chg1", 4'h4, 4'h0, 1'b0, 8'd1);
        for (int k = 6; k <= 8; k++) begin
            bus.din = C_B; cyc();
        end
        bus.din = C_A; cyc();
        check_outs("mins ok chg2", 4'h4, 4'h0, 1'b0, 8'd2);

        // Saturation on ch0, then clr colliding with a change
        do_reset();
        bus.mode = 8'h01; bus.cnt_sel = 2'd0; bus.din = 32'h0000_0055;
        cyc();
        check("sat load chg", 32'(bus.chg), 32'h0);
        for (int n = 1; n <= 300; n++) begin
            bus.din = (n % 2 == 1) ? 32'h0000_00AA : 32'h0000_0055;
            cyc();
            if (n == 1)   check("sat n1 cnt",   32'(bus.cnt_out), 32'd1);
            if (n == 255) check("sat n255 cnt", 32'(bus.cnt_out), 32'd255);
            if (n == 256) check("sat n256 cnt", 32'(bus.cnt_out), 32'd255);
        end
        check_outs("sat n300", 4'h1, 4'h0, 1'b0, 8'd255);
        bus.din = 32'h0000_00AA; bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
        check_outs("clr collide", 4'h1, 4'h0, 1'b0, 8'd1);
        cyc();
        check_outs("after clr load", 4'h0, 4'h0, 1'b0, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/change_monitor.md
# change_monitor

Multi-channel synthesizable change monitor: registers each channel's sample every clock and flags when it differs from the previous sample. Per channel it can also enforce a maximum hold time or a minimum stable time. It counts change events per channel and raises sticky violation flags plus an interrupt. It sits beside datapath buses in simulation and silicon as the hardware counterpart of our changed/stable property checks.

## Interface
- N_CH, 4: number of monitored channels (1..16)
- DW, 8: bits per channel
- CNT_W, 8: width of per-channel saturating change counter
- HOLD_MAX, 10: mode 10 limit; max stable samples allowed (1..2^CNT_W-2)
- MIN_STABLE, 3: mode 11 limit; min stable samples required between changes (1..2^CNT_W-2)

- clk  in  1  sampling clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; when low nothing is sampled and all state holds
- mode  in  2*N_CH  per-channel mode, channel i at [2i+1:2i]: 00 off, 01 change-detect, 10 max-hold, 11 min-stable
- din  in  N_CH*DW  channel data, channel i at [DW*i+DW-1:DW*i]
- clr  in  1  synchronous pulse: clears counters and sticky flags
- cnt_sel  in  $clog2(N_CH) (min 1)  channel selected for cnt_out
- chg  out  N_CH  registered one-cycle change pulse per channel
- viol  out  N_CH  sticky violation flag per channel
- irq  out  1  registered OR of viol
- cnt_out  out  CNT_W  change count of channel cnt_sel (combinational mux of registered counters)

## Operation
- Per channel state: prev[DW], valid, stab[CNT_W] (saturating), cnt[CNT_W] (saturating), viol.
- Channel active when en=1 and mode != 00. Inactive channels hold all state and drive chg=0. Mode 00 additionally clears valid.
- First active sample after reset, clr, or a mode change loads prev, sets valid, stab=0, no chg. No $changed-style compare against the reset value.
- A change means active, valid=1 and din_i != prev. On a change: chg_i=1 next cycle, cnt+1 (saturate at all-ones), stab=0, prev=din.
- No change while active: stab+1 (saturate), chg_i=0.
- Mode 10, max-hold: viol set when stab would reach HOLD_MAX, i.e. HOLD_MAX consecutive samples with no change. It fires once per stable run.
- Mode 11, min-stable: viol set on a change when stab < MIN_STABLE at that sample.
- Mode 01: viol is never set.
- Mode change on a channel: valid cleared, stab=0. cnt and viol are kept.
- clr: cnt=0, viol=0, valid=0, stab=0 on all channels. A violation or change detected in the same cycle as clr wins: viol and cnt show the new event (cnt=1).
- Multi-bit: any bit differing counts as one change, so cnt increments by 1.

## Timing
- Reset values: chg=0, viol=0, irq=0, cnt_out=0. Internal prev=0, valid=0, stab=0, cnt=0.
- Latency: din at posedge k differing from posedge k-1 gives chg high for exactly the cycle after edge k (1 cycle).
- viol and irq assert in the same cycle as the corresponding chg, or in the cycle after the HOLD_MAX-th stable sample. irq follows viol with 0 extra cycles; irq is registered from the next-state viol.
- cnt_out reflects an increment in the same cycle chg is visible.
- en low freezes stab. A gap does not count as stable time or as a change. The first sample after en rises is compared against prev.
- rst_n assertion mid-operation clears everything immediately (asynchronous). Deassertion takes effect at the next posedge.

## Test plan
- Reset: rst_n=0 mid-run with viol and cnt nonzero -> all outputs 0 at once. The first sample after release gives chg=0 even if din is nonzero.
- Change detect: ch0 mode 01, din0 sequence 5,5,7,7,2 -> chg0 pulses after the 3rd and 5th samples only; cnt_sel=0 gives cnt_out=2; viol0=0.
- Max-hold: ch1 mode 10, HOLD_MAX=10, din1 held constant 12 samples -> viol1 and irq rise after the 11th sample (10 stable after the first). A later change does not clear them; clr does.
- Min-stable: ch2 mode 11, MIN_STABLE=3, toggles with 1 stable sample between them -> viol2 set with the 2nd chg. With 3 stable samples between toggles -> viol2 stays 0.
- Saturation and clr collision: CNT_W=8, 300 changes -> cnt_out=255. Assert clr in the same cycle as a change -> cnt_out=1 next cycle.
- Enable and mode: en=0 for 5 cycles while din changes -> no chg. Switching ch3 from 01 to 11 -> no chg on the next sample and cnt is retained.
